// File: rtl/down_counter_if.sv
// ============================================================================
// Module      : down_counter_if
// Description : Control/status bundle for down_counter: enable, load strobe,
//               load value, count, terminal-count pulse and busy flag.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface down_counter_if #(
    parameter int WIDTH = 8
);
    logic             E;
    logic             ld;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] d;
    logic             q;
    logic             busy;

    modport master (
        output E, ld, din,
        input  d, q, busy
    );

    modport slave (
        input  E, ld, din,
        output d, q, busy
    );
endinterface

`default_nettype wire

// File: rtl/down_counter.sv
// ============================================================================
// Module      : down_counter
// Description : Loadable down counter with IDLE/RUN/DONE control and a
//               one-cycle terminal-count pulse. Define
//               DOWN_COUNTER_AUTORELOAD_EN to reload from the last loaded
//               value after each DONE cycle.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module down_counter #(
    parameter int WIDTH = 8
) (
    input  wire logic          ph1,
    input  wire logic          reset,
    down_counter_if.slave      bus
);
    localparam logic [1:0]       c_S_IDLE = 2'd0;
    localparam logic [1:0]       c_S_RUN  = 2'd1;
    localparam logic [1:0]       c_S_DONE = 2'd2;
    localparam logic [WIDTH-1:0] c_ZERO   = '0;
    localparam logic [WIDTH-1:0] c_ONE    = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             q_q;
    logic             busy_q;
`ifdef DOWN_COUNTER_AUTORELOAD_EN
    logic [WIDTH-1:0] rld_q, rld_d;
`endif

    always_comb begin
        state_d = state_q;
        count_d = count_q;
`ifdef DOWN_COUNTER_AUTORELOAD_EN
        rld_d   = rld_q;
`endif
        if (bus.ld) begin
            // A load is honoured in every state, DONE included, and beats E.
            count_d = bus.din;
            state_d = (bus.din != c_ZERO) ? c_S_RUN : c_S_IDLE;
`ifdef DOWN_COUNTER_AUTORELOAD_EN
            rld_d   = bus.din;
`endif
        end else begin
            case (state_q)
                c_S_RUN: begin
                    if (bus.E) begin
                        count_d = count_q - c_ONE;
                        if (count_q == c_ONE) begin
                            state_d = c_S_DONE;
                        end
                    end
                end
                c_S_DONE: begin
`ifdef DOWN_COUNTER_AUTORELOAD_EN
                    count_d = rld_q;
                    state_d = c_S_RUN;
`else
                    state_d = c_S_IDLE;
`endif
                end
                default: begin
                    state_d = c_S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge ph1) begin
        if (reset) begin
            state_q <= c_S_IDLE;
            count_q <= c_ZERO;
            q_q     <= 1'b0;
            busy_q  <= 1'b0;
`ifdef DOWN_COUNTER_AUTORELOAD_EN
            rld_q   <= c_ZERO;
`endif
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            q_q     <= (state_d == c_S_DONE);
            busy_q  <= (state_d == c_S_RUN);
`ifdef DOWN_COUNTER_AUTORELOAD_EN
            rld_q   <= rld_d;
`endif
        end
    end

    assign bus.d    = count_q;
    assign bus.q    = q_q;
    assign bus.busy = busy_q;
endmodule

`default_nettype wire

// File: tb/tb_down_counter.sv
// ============================================================================
// Module      : tb_down_counter
// Description : Self-checking bench for down_counter: directed scenarios with
//               literal expectations plus randomized traffic against a model.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_down_counter;
    localparam int W = 8;

    logic ph1;
    logic reset;
    int   checks;
    int   errors;
    bit   chk_en;

    down_counter_if #(.WIDTH(W)) bus ();

    down_counter #(.WIDTH(W)) dut (
        .ph1   (ph1),
        .reset (reset),
        .bus   (bus)
    );

    initial ph1 = 1'b0;
    always #5 ph1 = ~ph1;

    // Model in terms of visible behaviour: count value, busy, one-cycle pulse.
    int m_d;
    int m_rld;
    bit m_busy;
    bit m_q;

    always @(posedge ph1) begin
        if (reset) begin
            m_d = 0; m_rld = 0; m_busy = 0; m_q = 0;
        end else if (bus.ld) begin
            m_d    = int'(bus.din);
            m_rld  = int'(bus.din);
            m_busy = (bus.din != 0);
            m_q    = 0;
        end else if (m_q) begin
            m_q = 0;
`ifdef DOWN_COUNTER_AUTORELOAD_EN
            m_d    = m_rld;
            m_busy = 1;
`else
            m_busy = 0;
`endif
        end else if (m_busy && bus.E) begin
            m_d = m_d - 1;
            if (m_d == 0) begin
                m_busy = 0;
                m_q    = 1;
            end
        end
    end

    always @(negedge ph1) begin
        if (chk_en) begin
            checks++;
            if (int'(bus.d) != m_d || bus.q !== m_q || bus.busy !== m_busy) begin
                errors++;
                $display("FAIL model t=%0t d=%0d q=%0b busy=%0b required d=%0d q=%0b busy=%0b",
                         $time, bus.d, bus.q, bus.busy, m_d, m_q, m_busy);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic chk3(input string name, input int ed, input int eq, input int eb);
        chk({name, ".d"},    int'(bus.d),    ed);
        chk({name, ".q"},    int'(bus.q),    eq);
        chk({name, ".busy"}, int'(bus.busy), eb);
    endtask

    task automatic cyc(input bit r, input bit e, input bit l, input logic [W-1:0] v);
        reset  = r;
        bus.E  = e;
        bus.ld = l;
        bus.din = v;
        @(posedge ph1);
        #1;
    endtask

    initial begin
        checks = 0; errors = 0; chk_en = 0;
        reset = 1; bus.E = 0; bus.ld = 0; bus.din = '0;
        @(posedge ph1); #1;
        chk_en = 1;
        cyc(1, 0, 0, 0);
        chk3("reset", 0, 0, 0);

        // load 3, count continuously
        cyc(0, 0, 1, 8'd3);  chk3("ld3", 3, 0, 1);
        cyc(0, 1, 0, 0);     chk3("cnt2", 2, 0, 1);
        cyc(0, 1, 0, 0);     chk3("cnt1", 1, 0, 1);
        cyc(0, 1, 0, 0);     chk3("cnt0", 0, 1, 0);
        cyc(0, 1, 0, 0);
`ifdef DOWN_COUNTER_AUTORELOAD_EN
        chk3("after_done", 3, 0, 1);
`else
        chk3("after_done", 0, 0, 0);
`endif

        // enable gaps
        cyc(0, 0, 1, 8'd5);  chk3("ld5", 5, 0, 1);
        cyc(0, 1, 0, 0);     chk3("gap_e1", 4, 0, 1);
        cyc(0, 0, 0, 0);     chk3("gap_e0a", 4, 0, 1);
        cyc(0, 0, 0, 0);     chk3("gap_e0b", 4, 0, 1);
        cyc(0, 1, 0, 0);     chk3("gap_e1b", 3, 0, 1);

        // idle at zero does not wrap; loading zero gives no pulse
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 10; i++) cyc(0, 1, 0, 0);
        chk3("idle_hold", 0, 0, 0);
        cyc(0, 1, 1, 8'd0);  chk3("ld0", 0, 0, 0);
        cyc(0, 1, 0, 0);     chk3("ld0_next", 0, 0, 0);

        // load wins over enable mid-count
        cyc(0, 0, 1, 8'd200); chk3("ld200", 200, 0, 1);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);      chk3("cnt198", 198, 0, 1);
        cyc(0, 1, 1, 8'd2);   chk3("ld2_wins", 2, 0, 1);
        cyc(0, 1, 0, 0);      chk3("ld2_1", 1, 0, 1);
        cyc(0, 1, 0, 0);      chk3("ld2_0", 0, 1, 0);

        // load during DONE: pulse already showing, load at next edge
        cyc(0, 1, 1, 8'd4);   chk3("ld_in_done", 4, 0, 1);

        // reset overrides load and enable mid-count
        cyc(0, 0, 1, 8'd9);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);      chk3("at7", 7, 0, 1);
        cyc(1, 1, 1, 8'd50);  chk3("rst_mid", 0, 0, 0);

        // periodic behaviour
        cyc(0, 1, 1, 8'd2);   chk3("p_ld", 2, 0, 1);
        cyc(0, 1, 0, 0);      chk3("p_1", 1, 0, 1);
        cyc(0, 1, 0, 0);      chk3("p_0", 0, 1, 0);
        cyc(0, 1, 0, 0);
`ifdef DOWN_COUNTER_AUTORELOAD_EN
        chk3("p_re2", 2, 0, 1);
        cyc(0, 1, 0, 0);      chk3("p_re1", 1, 0, 1);
        cyc(0, 1, 0, 0);      chk3("p_re0", 0, 1, 0);
`else
        chk3("p_idle", 0, 0, 0);
        cyc(0, 1, 0, 0);      chk3("p_idle2", 0, 0, 0);
`endif

        // randomized traffic, checked every cycle by the model
        for (int i = 0; i < 3000; i++) begin
            logic [W-1:0] v;
            v = ($urandom_range(0, 1) == 1) ? W'($urandom_range(0, 4)) : W'($urandom_range(0, 255));
            cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 9) == 0), v);
        end

        chk_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/down_counter.md
DOWN_COUNTER -- requirements
Module: down_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, count/load width in bits.
REQ-002 SHALL have port ph1  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port E  input  1  count enable; decrement only when high.
REQ-005 SHALL have port ld  input  1  load strobe; samples din.
REQ-006 SHALL have port din  input  WIDTH  load value.
REQ-007 SHALL have port d  output  WIDTH  current count, registered.
REQ-008 SHALL have port q  output  1  terminal-count pulse, registered.
REQ-009 SHALL have port busy  output  1  high while in RUN.
REQ-010 SHALL use one clock; reset SHALL be synchronous and active-high, named reset, with clock named ph1.

Function
REQ-011 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-012 SHALL, in any state, on ld=1 with din!=0: d<=din, next state RUN; ld SHALL take priority over E.
REQ-013 SHALL, in any state, on ld=1 with din==0: d<=0, next state IDLE, no q pulse.
REQ-014 SHALL, in RUN with ld=0 and E=1: d<=d-1 (modulo 2^WIDTH not reachable; d>=1 in RUN).
REQ-015 SHALL, in RUN with ld=0, E=1, d==1: d<=0, next state DONE.
REQ-016 SHALL, in RUN with ld=0 and E=0: hold d and state.
REQ-017 SHALL assert q=1 exactly during the cycle the FSM is in DONE; q=0 in all other states.
REQ-018 SHALL, in DONE with ld=0: leave DONE after exactly one cycle (destination per REQ-025/026); E ignored in DONE.
REQ-019 SHALL, in IDLE with ld=0: hold d regardless of E; no wrap from 0 to 2^WIDTH-1.
REQ-020 SHALL drive busy=1 iff state is RUN (registered, same cycle as state).
REQ-021 SHALL give one-cycle latency: d updates the edge after ld/E sampled; q rises the edge d reaches 0.
REQ-022 SHALL, with ld=1 while in DONE, still show q=1 for that cycle and apply the load at the following edge.
REQ-023 SHALL capture din into an internal reload register rld on every accepted ld.

Reset
REQ-024 SHALL, when reset=1 at a rising edge, set d=0, q=0, busy=0, rld=0, state IDLE; reset SHALL override ld and E, including mid-count and in DONE.

Configuration
REQ-025 SHALL, with macro DOWN_COUNTER_AUTORELOAD_EN defined, leave DONE (ld=0) to RUN with d<=rld (rld!=0 guaranteed by REQ-012/013), giving a periodic q pulse every rld enabled counts plus one DONE cycle.
REQ-026 SHALL, without DOWN_COUNTER_AUTORELOAD_EN, leave DONE (ld=0) to IDLE with d held at 0; rld register MAY be omitted.

Verification
REQ-027 SHALL cover: reset, ld=1 din=3, then E=1 continuous -> d=3,2,1,0 on successive edges; q=1 one cycle with d=0; busy=1 for cycles d=3..1; then IDLE, q=0.
REQ-028 SHALL cover: din=5 loaded, E toggles 1,0,0,1 -> d=5,4,4,4,3; busy stays 1, q stays 0.
REQ-029 SHALL cover: IDLE with d=0, E=1 for 10 cycles -> d stays 0, q=0, busy=0; ld=1 din=0 -> d=0, no q pulse.
REQ-030 SHALL cover: din=200 loaded, counting, ld=1 din=2 and E=1 same cycle -> d=2 next edge (load wins), then 1,0, q pulse.
REQ-031 SHALL cover: reset=1 asserted at d=7 in RUN with E=1 and ld=1 -> d=0, q=0, busy=0 next edge; rld=0.
REQ-032 SHALL cover with DOWN_COUNTER_AUTORELOAD_EN: din=2, E=1 held -> d=2,1,0(q=1),2,1,0(q=1)...; q period 3 cycles; without macro, single q pulse then IDLE.
